// File: rtl/exec_stage_pipe_pkg.sv
// rtl/exec_stage_pipe_pkg.sv - ALU op codes and FSM state encoding for the execute stage
package exec_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_SLL   = 4'd8;
  localparam logic [3:0] ALU_SRL   = 4'd9;
  localparam logic [3:0] ALU_SRA   = 4'd10;
  localparam logic [3:0] ALU_LUI   = 4'd11;
  localparam logic [3:0] ALU_MULT  = 4'd12;
  localparam logic [3:0] ALU_MULTU = 4'd13;
  localparam logic [3:0] ALU_MFHI  = 4'd14;
  localparam logic [3:0] ALU_MFLO  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/exec_stage_pipe_if.sv
// rtl/exec_stage_pipe_if.sv - ID/EX operand bundle and EX/MEM result bundle
interface exec_if #(parameter int DATA_W = 32);
  localparam int SHW = $clog2(DATA_W);

  logic              i_valid;
  logic              o_ready;
  logic              i_stall;
  logic              i_flush;
  logic [DATA_W-1:0] i_pc_increment;
  logic [DATA_W-1:0] i_src1;
  logic [DATA_W-1:0] i_src2;
  logic [DATA_W-1:0] i_sign_extend;
  logic [SHW-1:0]    i_shamt;
  logic              i_sel_shift;
  logic              i_alu_src_sel;
  logic [3:0]        i_alu_op;
  logic              o_valid;
  logic [DATA_W-1:0] o_alu_result;
  logic              o_zero;
  logic [DATA_W-1:0] o_br_address;
  logic              o_hilo_wr;
  logic [DATA_W-1:0] o_hi;
  logic [DATA_W-1:0] o_lo;

  modport master (
    output i_valid, i_stall, i_flush, i_pc_increment, i_src1, i_src2, i_sign_extend,
           i_shamt, i_sel_shift, i_alu_src_sel, i_alu_op,
    input  o_ready, o_valid, o_alu_result, o_zero, o_br_address, o_hilo_wr, o_hi, o_lo
  );

  modport slave (
    input  i_valid, i_stall, i_flush, i_pc_increment, i_src1, i_src2, i_sign_extend,
           i_shamt, i_sel_shift, i_alu_src_sel, i_alu_op,
    output o_ready, o_valid, o_alu_result, o_zero, o_br_address, o_hilo_wr, o_hi, o_lo
  );
endinterface

// File: rtl/exec_stage_pipe_mul_iter.sv
// rtl/exec_stage_pipe_mul_iter.sv - radix-2 shift-add multiplier, one bit per cycle
module mul_iter #(
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                neg_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [2*DATA_W-1:0] product_o
);
  localparam int CW = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0]   mcand_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [CW-1:0]       cnt_q;
  logic                neg_q;
  logic [DATA_W:0]     sum;

  assign busy_o    = (cnt_q != '0);
  // done_o marks the final step; product_o is stable from the next cycle until the next start
  assign done_o    = busy_o && (cnt_q == CW'(1));
  assign sum       = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign product_o = neg_q ? -acc_q : acc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
    end else if (abort_i) begin
      cnt_q   <= '0;
    end else if (start_i) begin
      mcand_q <= a_i;
      acc_q   <= {{DATA_W{1'b0}}, b_i};
      cnt_q   <= CW'(DATA_W);
      neg_q   <= neg_i;
    end else if (busy_o) begin
      acc_q   <= {sum, acc_q[DATA_W-1:1]};
      cnt_q   <= cnt_q - CW'(1);
    end
  end
endmodule

// File: rtl/exec_stage_pipe.sv
// rtl/exec_stage_pipe.sv - registered MIPS execute stage with iterative HI/LO multiplier
module exec_stage_pipe
  import exec_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter bit MUL_SIGNED_FIX = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  exec_if.slave bus
);
  localparam int SHW = $clog2(DATA_W);

  state_t              state_q, state_d;
  logic                valid_q, valid_d, zero_q, zero_d, hilo_wr_q, hilo_wr_d;
  logic [DATA_W-1:0]   result_q, result_d, br_q, br_d, hi_q, hi_d, lo_q, lo_d;
  logic                ready, accept, is_mul, signed_mul;
  logic [DATA_W-1:0]   opb, alu_res, br_sum, mag_a, mag_b;
  logic [SHW-1:0]      sh;
  logic                mul_start, mul_abort, mul_neg, mul_busy, mul_done;
  logic [2*DATA_W-1:0] product;

  assign ready      = !i_rst && (state_q == ST_IDLE) && !bus.i_stall;
  assign accept     = bus.i_valid && ready && !bus.i_flush;
  assign is_mul     = (bus.i_alu_op == ALU_MULT) || (bus.i_alu_op == ALU_MULTU);
  assign signed_mul = MUL_SIGNED_FIX && (bus.i_alu_op == ALU_MULT);
  assign opb        = bus.i_alu_src_sel ? bus.i_sign_extend : bus.i_src2;
  assign sh         = bus.i_sel_shift ? bus.i_src1[SHW-1:0] : bus.i_shamt;
  assign br_sum     = bus.i_pc_increment + (bus.i_sign_extend << 2);
  assign mag_a      = (signed_mul && bus.i_src1[DATA_W-1]) ? -bus.i_src1 : bus.i_src1;
  assign mag_b      = (signed_mul && opb[DATA_W-1]) ? -opb : opb;
  assign mul_neg    = signed_mul && (bus.i_src1[DATA_W-1] ^ opb[DATA_W-1]);

  always_comb begin
    alu_res = '0;
    case (bus.i_alu_op)
      ALU_ADD:  alu_res = bus.i_src1 + opb;
      ALU_SUB:  alu_res = bus.i_src1 - opb;
      ALU_AND:  alu_res = bus.i_src1 & opb;
      ALU_OR:   alu_res = bus.i_src1 | opb;
      ALU_XOR:  alu_res = bus.i_src1 ^ opb;
      ALU_NOR:  alu_res = ~(bus.i_src1 | opb);
      ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(bus.i_src1) < $signed(opb)};
      ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, bus.i_src1 < opb};
      ALU_SLL:  alu_res = opb << sh;
      ALU_SRL:  alu_res = opb >> sh;
      ALU_SRA:  alu_res = DATA_W'($signed(opb) >>> sh);
      ALU_LUI:  alu_res = opb << (DATA_W/2);
      ALU_MFHI: alu_res = hi_q;
      ALU_MFLO: alu_res = lo_q;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    zero_d    = zero_q;
    hilo_wr_d = hilo_wr_q;
    result_d  = result_q;
    br_d      = br_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mul_start = 1'b0;
    mul_abort = 1'b0;
    if (bus.i_flush) begin
      state_d   = ST_IDLE;
      valid_d   = 1'b0;
      hilo_wr_d = 1'b0;
      mul_abort = 1'b1;
    end else begin
      if (!bus.i_stall) begin
        valid_d   = 1'b0;
        hilo_wr_d = 1'b0;
      end
      case (state_q)
        ST_IDLE: if (accept) begin
          br_d = br_sum;
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            valid_d  = 1'b1;
          end
        end
        ST_MUL: begin
          if (mul_done)      state_d = ST_DONE;
          else if (!mul_busy) state_d = ST_IDLE;
        end
        // the finished product waits here while downstream stalls
        ST_DONE: if (!bus.i_stall) begin
          hi_d      = product[2*DATA_W-1:DATA_W];
          lo_d      = product[DATA_W-1:0];
          result_d  = product[DATA_W-1:0];
          zero_d    = (product[DATA_W-1:0] == '0);
          valid_d   = 1'b1;
          hilo_wr_d = 1'b1;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      zero_q    <= 1'b0;
      hilo_wr_q <= 1'b0;
      result_q  <= '0;
      br_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      zero_q    <= zero_d;
      hilo_wr_q <= hilo_wr_d;
      result_q  <= result_d;
      br_q      <= br_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .start_i   (mul_start),
    .abort_i   (mul_abort),
    .neg_i     (mul_neg),
    .a_i       (mag_a),
    .b_i       (mag_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (product)
  );

  assign bus.o_ready      = ready;
  assign bus.o_valid      = valid_q;
  assign bus.o_alu_result = result_q;
  assign bus.o_zero       = zero_q;
  assign bus.o_br_address = br_q;
  assign bus.o_hilo_wr    = hilo_wr_q;
  assign bus.o_hi         = hi_q;
  assign bus.o_lo         = lo_q;
endmodule

// File: doc/exec_stage_pipe.md
Name: exec_stage_pipe

Overview:
Parametrised, registered successor to the combinational execute stage of the MIPS five-stage pipeline. It takes decoded ID/EX operands and produces a registered EX/MEM result. The result carries the ALU output, the zero flag and the branch target. It adds an iterative HI/LO multiplier with a stall handshake and flush support.

Parameters:
DATA_W, 32, operand/result width (power of two, >= 8)
SHW, $clog2(DATA_W), shift-amount width (derived localparam, not overridable)
MUL_SIGNED_FIX, 1, 1 = MULT signed via magnitude+sign correction; 0 = MULT treated as MULTU

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_valid  in  1  ID/EX operands valid this cycle
o_ready  out  1  stage can accept; low while multiplier busy or output stalled
i_stall  in  1  downstream hold; output register keeps its value
i_flush  in  1  kill accepted/in-flight op (branch mispredict)
i_pc_increment  in  DATA_W  PC+4 of the instruction
i_src1  in  DATA_W  rs operand
i_src2  in  DATA_W  rt operand
i_sign_extend  in  DATA_W  sign-extended immediate
i_shamt  in  SHW  instruction shamt field
i_sel_shift  in  1  1 = shift by i_src1[SHW-1:0], 0 = shift by i_shamt
i_alu_src_sel  in  1  1 = operand B is i_sign_extend, 0 = i_src2
i_alu_op  in  4  op code (values in package)
o_valid  out  1  EX/MEM result valid
o_alu_result  out  DATA_W  registered result
o_zero  out  1  registered (o_alu_result == 0)
o_br_address  out  DATA_W  registered i_pc_increment + (i_sign_extend << 2), modulo 2^DATA_W
o_hilo_wr  out  1  result came from MULT/MULTU
o_hi  out  DATA_W  HI register
o_lo  out  DATA_W  LO register

Behaviour:
- Reset (async, i_rst=1): state IDLE; o_valid, o_hilo_wr, o_zero=0; o_alu_result, o_br_address, o_hi, o_lo=0; o_ready=0 while in reset, 1 after.
- Accept occurs when i_valid & o_ready & !i_flush.
- Single-cycle ops: ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI, MFHI, MFLO.
  - Result registered on the accept edge, so latency is 1 cycle; o_valid=1 the following cycle.
  - ADD/SUB wrap, with no overflow trap.
  - SLT is signed; SLTU is unsigned; both yield a 0/1 result.
  - SRA is arithmetic.
  - LUI = B << (DATA_W/2).
  - MFHI/MFLO return the current o_hi/o_lo; if a MULT is in flight they cannot be accepted (o_ready=0).
- MULT/MULTU:
  - FSM IDLE -> MUL (DATA_W cycles, radix-2 shift-add, one bit per cycle) -> DONE -> IDLE.
  - o_ready=0 in MUL and DONE.
  - In DONE, {o_hi, o_lo} are updated to the 2*DATA_W product and the output register loads o_alu_result=LO, o_hilo_wr=1, o_valid=1.
  - Total latency is DATA_W+1 cycles from accept to o_valid.
  - Signed MULT: operands converted to magnitudes; product negated when sign bits differ.
- o_valid is 1 only in the cycle after a result is produced, unless held by i_stall.
  - While i_stall=1, all outputs hold and o_ready=0.
  - An in-flight multiply continues counting and waits in DONE until i_stall falls.
- i_flush:
  - Next cycle o_valid=0.
  - An in-flight MUL/DONE returns to IDLE; HI/LO stay unchanged.
  - An i_valid in the same cycle is dropped.
  - Flush overrides stall.
- o_br_address and o_zero are computed for every accepted op.
- Undefined i_alu_op gives o_alu_result=0 and o_valid=1.

Decomposition:
- Package exec_pkg holds:
  - ALU op localparams: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10, LUI=11, MULT=12, MULTU=13, MFHI=14, MFLO=15.
  - FSM state encoding: IDLE, MUL, DONE.
- One sub-module, mul_iter:
  - Parametrised DATA_W sequential multiplier.
  - start/busy/done handshake and abort input.
  - Outputs a 2*DATA_W product.
- The ALU, shifter and branch adder remain inline combinational logic.

Test Plan:
- Reset mid-MULT: issue MULT, assert i_rst at cycle 5 -> all outputs 0 immediately; o_ready=1 one cycle after release.
- ADD src1=0x7FFFFFFF, src2=1 -> o_alu_result=0x80000000, o_zero=0, o_valid=1 one cycle after accept. SUB 5-5 -> result 0, o_zero=1.
- SRA variable: i_sel_shift=1, src1=4, src2=0x80000000 -> 0xF8000000. SLL with i_shamt=31, src2=1 -> 0x80000000.
- MULT src1=-3 (0xFFFFFFFD), src2=7 -> o_ready low 33 cycles; o_hi=0xFFFFFFFF, o_lo=0xFFFFFFEB, o_hilo_wr=1. MULTU 0xFFFFFFFF*2 -> HI=1, LO=0xFFFFFFFE.
- Branch: i_pc_increment=0x100, i_sign_extend=0xFFFFFFFE -> o_br_address=0xF8. i_stall held 3 cycles -> outputs unchanged and o_ready=0.
- Flush at cycle 10 of MULT -> o_valid stays 0, HI/LO keep prior values. A following MFLO returns the old LO.
